uart_rx_fsm: RTL and testbench

- Asynchronous serial (UART 8N1/8E1/8O1) receiver. It is the receiving end of the team's serial link and pairs with the existing transmit-side FSM.
- Oversamples `rxd` with a clock-cycle counter, recovers frames with a state machine, and presents each byte on a valid/ready output port.
- Sits between the board RX pin and the command-parsing logic.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_fsm_sync_2ff.sv | 24 ++
 rtl/uart_rx_fsm.sv | 141 ++++++++++++++
 tb/tb_uart_rx_fsm.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the serial receive path: state encoding, default bit
// timing and the parity check used by the receiver FSM.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5,
        DONE   = 3'd6
    } state_t;

    // Returns 1 when the received parity bit disagrees with the selected sense.
    function automatic logic parity_mismatch(input logic [7:0] data,
                                             input logic       pbit,
                                             input logic       odd);
        return ((^data) ^ pbit) != odd;
    endfunction

endpackage

// File: rtl/uart_rx_fsm_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is
// selectable so idle-high lines come out of reset idle.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= RST_VAL;
            q        <= RST_VAL;
        end else begin
            meta_reg <= d;
            q        <= meta_reg;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver (8 data bits, optional parity, 1 stop bit) with a valid/ready
// output port, one-cycle error pulses and a sticky overrun flag.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic          rxd_s;
    logic          rxd_d;
    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          par_bad_reg;
    logic          rearm_reg;
    logic          start_seen;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rxd_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rxd_d <= 1'b1;
        else        rxd_d <= rxd_s;
    end

    // A start bit that began while DONE was still draining has no visible
    // edge any more, so DONE arms IDLE to accept a plain low level once.
    assign start_seen = !rxd_s && (rxd_d || rearm_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            par_bad_reg <= 1'b0;
            rearm_reg   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            case (state_reg)
                IDLE: begin
                    rearm_reg   <= 1'b0;
                    par_bad_reg <= 1'b0;
                    cnt_reg     <= '0;
                    if (start_seen)
                        state_reg <= START;
                end
                START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= rxd_s ? IDLE : DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_reg == FULL_LAST) begin
                        cnt_reg     <= '0;
                        shift_reg   <= {rxd_s, shift_reg[7:1]};
                        bit_idx_reg <= bit_idx_reg + 1'b1;
                        if (bit_idx_reg == 3'd7)
                            state_reg <= PARITY_EN ? PARITY : STOP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt_reg == FULL_LAST) begin
                        cnt_reg     <= '0;
                        par_bad_reg <= parity_mismatch(shift_reg, rxd_s, PARITY_ODD);
                        state_reg   <= STOP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_reg == FULL_LAST) begin
                        cnt_reg <= '0;
                        if (rxd_s) begin
                            state_reg <= DONE;
                        end else begin
                            frame_err <= 1'b1;
                            state_reg <= BREAK;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxd_s)
                        state_reg <= DONE;
                end
                DONE: begin
                    parity_err <= par_bad_reg;
                    rearm_reg  <= 1'b1;
                    // An unread byte still in the output register wins; the new one is dropped.
                    if (!rx_valid || rx_ready) begin
                        rx_data  <= shift_reg;
                        rx_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: one receiver without parity, one with even parity,
// driven with directed and random frames and compared against a frame model.
module tb_uart_rx_fsm;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] rxd = 2'b11;
    logic [1:0] rx_ready = 2'b11;
    logic [1:0] rx_valid;
    logic [1:0] frame_err;
    logic [1:0] parity_err;
    logic [1:0] overrun;
    logic [7:0] rx_data0;
    logic [7:0] rx_data1;

    int         n_checks = 0;
    int         n_fail = 0;
    longint     cyc = 0;
    longint     t_high = 0;

    int         deliv[2];
    int         fe_cnt[2];
    int         pe_cnt[2];
    int         streak[2];
    int         max_streak[2];
    logic [7:0] last_data[2];
    longint     t_deliv[2];

    uart_rx_fsm #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd[0]),
        .rx_data    (rx_data0),
        .rx_valid   (rx_valid[0]),
        .rx_ready   (rx_ready[0]),
        .frame_err  (frame_err[0]),
        .parity_err (parity_err[0]),
        .overrun    (overrun[0])
    );

    uart_rx_fsm #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd[1]),
        .rx_data    (rx_data1),
        .rx_valid   (rx_valid[1]),
        .rx_ready   (rx_ready[1]),
        .frame_err  (frame_err[1]),
        .parity_err (parity_err[1]),
        .overrun    (overrun[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe both receivers away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rx_valid[i]) begin
                streak[i]++;
                if (streak[i] > max_streak[i]) max_streak[i] = streak[i];
            end else begin
                streak[i] = 0;
            end
            if (rx_valid[i] && rx_ready[i]) begin
                deliv[i]++;
                last_data[i] = (i == 1) ? rx_data1 : rx_data0;
                t_deliv[i]   = cyc;
            end
            if (frame_err[i])  fe_cnt[i]++;
            if (parity_err[i]) pe_cnt[i]++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats(input int w);
        deliv[w]      = 0;
        fe_cnt[w]     = 0;
        pe_cnt[w]     = 0;
        max_streak[w] = 0;
        t_deliv[w]    = 0;
    endtask

    // Hold line w at level v for n clocks; always returns 1 time unit after a rising edge.
    task automatic line(input int w, input logic v, input int n);
        rxd[w] = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int w, input logic [7:0] b, input logic pbit,
                              input logic stopb, input int stop_len);
        line(w, 1'b0, CPB);
        for (int i = 0; i < 8; i++) line(w, b[i], CPB);
        if (w == 1) line(w, pbit, CPB);
        line(w, stopb, stopb ? CPB : stop_len);
        t_high = cyc;
        line(w, 1'b1, 2 * CPB + 8);
    endtask

    // Model: a frame delivers its byte once; the stop level and the count of ones
    // decide the error pulses.
    task automatic run_frame(input int w, input logic [7:0] b, input logic pbit,
                             input logic stopb, input int stop_len);
        logic exp_pe;
        exp_pe = (w == 1) ? logic'((($countones(b) + int'(pbit)) % 2) != 0) : 1'b0;
        clear_stats(w);
        send_frame(w, b, pbit, stopb, stop_len);
        $display("frame dut%0d byte=0x%02h pbit=%0b stop=%0b -> data=0x%02h fe=%0d pe=%0d",
                 w, b, pbit, stopb, last_data[w], fe_cnt[w], pe_cnt[w]);
        check_eq($sformatf("deliv_count_d%0d", w), 32'(deliv[w]), 32'd1);
        check_eq($sformatf("rx_data_d%0d", w), 32'(last_data[w]), 32'(b));
        check_eq($sformatf("valid_width_d%0d", w), 32'(max_streak[w]), 32'd1);
        check_eq($sformatf("frame_err_d%0d", w), 32'(fe_cnt[w]), stopb ? 32'd0 : 32'd1);
        check_eq($sformatf("parity_err_d%0d", w), 32'(pe_cnt[w]), 32'(exp_pe));
        if (!stopb)
            check_eq("deliver_after_break", 32'(t_deliv[w] > t_high), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            clear_stats(i);
            streak[i]    = 0;
            last_data[i] = 8'h00;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_data0", 32'(rx_data0), 32'd0);
        check_eq("rst_data1", 32'(rx_data1), 32'd0);
        check_eq("rst_errs", 32'({frame_err, parity_err}), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        run_frame(0, 8'hA5, 1'b0, 1'b1, CPB);

        // Short low glitch must be rejected in START
        clear_stats(0);
        line(0, 1'b0, 4);
        line(0, 1'b1, 3 * CPB);
        $display("glitch dut0 -> deliv=%0d fe=%0d valid=%0b", deliv[0], fe_cnt[0], rx_valid[0]);
        check_eq("glitch_deliv", 32'(deliv[0]), 32'd0);
        check_eq("glitch_fe", 32'(fe_cnt[0]), 32'd0);
        check_eq("glitch_valid", 32'(rx_valid[0]), 32'd0);

        run_frame(0, 8'h3C, 1'b0, 1'b0, 40);
        run_frame(1, 8'h07, 1'b1, 1'b1, CPB);
        run_frame(1, 8'h07, 1'b0, 1'b1, CPB);

        for (int k = 0; k < 6; k++) begin
            logic [7:0] b;
            logic       sb;
            b  = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 3) != 0);
            run_frame(0, b, 1'b0, sb, int'($urandom_range(CPB, 3 * CPB)));
            b = 8'($urandom_range(0, 255));
            run_frame(1, b, 1'($urandom_range(0, 1)), 1'b1, CPB);
        end

        // Backpressure: second byte is dropped and overrun latches
        rx_ready[0] = 1'b0;
        clear_stats(0);
        send_frame(0, 8'h11, 1'b0, 1'b1, CPB);
        $display("bp first  -> valid=%0b data=0x%02h ovr=%0b", rx_valid[0], rx_data0, overrun[0]);
        check_eq("bp1_valid", 32'(rx_valid[0]), 32'd1);
        check_eq("bp1_data", 32'(rx_data0), 32'h11);
        check_eq("bp1_overrun", 32'(overrun[0]), 32'd0);
        send_frame(0, 8'h22, 1'b0, 1'b1, CPB);
        $display("bp second -> valid=%0b data=0x%02h ovr=%0b", rx_valid[0], rx_data0, overrun[0]);
        check_eq("bp2_valid", 32'(rx_valid[0]), 32'd1);
        check_eq("bp2_data", 32'(rx_data0), 32'h11);
        check_eq("bp2_overrun", 32'(overrun[0]), 32'd1);
        rx_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        rx_ready[0] = 1'b0;
        @(negedge clk);
        $display("bp accept -> valid=%0b ovr=%0b", rx_valid[0], overrun[0]);
        check_eq("bp_accept_valid", 32'(rx_valid[0]), 32'd0);
        check_eq("bp_accept_overrun", 32'(overrun[0]), 32'd1);
        rx_ready[0] = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of data bit 4 aborts asynchronously
        clear_stats(0);
        line(0, 1'b0, CPB);
        for (int i = 0; i < 4; i++) line(0, i[0], CPB);
        rxd[0] = 1'b1;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        $display("mid-frame reset -> valid=%0b data=0x%02h ovr=%0b", rx_valid[0], rx_data0, overrun[0]);
        check_eq("arst_valid", 32'(rx_valid[0]), 32'd0);
        check_eq("arst_data", 32'(rx_data0), 32'd0);
        check_eq("arst_overrun", 32'(overrun[0]), 32'd0);
        check_eq("arst_errs", 32'({frame_err[0], parity_err[0]}), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        line(0, 1'b1, 3 * CPB);
        check_eq("arst_no_partial", 32'(deliv[0]), 32'd0);
        run_frame(0, 8'h5A, 1'b0, 1'b1, CPB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
